device_uart_tx: RTL and testbench

DEVICE_UART_TX -- requirements
Module: device_uart_tx

---
 rtl/device_uart_tx.sv | 209 ++++++++++++++++++++
 tb/tb_device_uart_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/device_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a power-of-two TX FIFO, a runtime baud divisor
// and a sticky overflow flag. Read data is registered and lags the read strobe by one cycle.
module device_uart_tx #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  device_core_id,
  input  logic        device_write_en,
  input  logic        device_read_en,
  input  logic [9:0]  device_addr,
  input  logic [15:0] device_data_out,
  output logic [15:0] device_data_in,
  output logic        uart_tx
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [9:0] AddrTxData  = 10'h000;
  localparam logic [9:0] AddrStatus  = 10'h001;
  localparam logic [9:0] AddrDivisor = 10'h002;
  localparam logic [9:0] AddrCoreId  = 10'h003;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_depth_check
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [7:0]      fifo_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     divisor_q, divisor_d;
  logic [15:0]     data_in_q, data_in_d;

  state_e          state_q, state_d;
  logic [15:0]     baud_cnt_q, baud_cnt_d;
  logic [15:0]     bit_div_q, bit_div_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic        wr_txdata, wr_status, wr_divisor;
  logic        fifo_full, fifo_empty;
  logic        push, pop, busy, baud_done;
  logic [15:0] status;
  logic [15:0] div_eff;

  // Register decode
  always_comb begin
    wr_txdata  = device_write_en && (device_addr == AddrTxData);
    wr_status  = device_write_en && (device_addr == AddrStatus);
    wr_divisor = device_write_en && (device_addr == AddrDivisor);
    fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    push       = wr_txdata && !fifo_full;
    pop        = (state_q == StIdle) && !fifo_empty;
    busy       = !fifo_empty || (state_q != StIdle);
    status     = {13'b0, overflow_q, busy, fifo_full};
    div_eff    = (divisor_q == '0) ? 16'd1 : divisor_q;
    baud_done  = (baud_cnt_q == '0);
  end

  // FIFO bookkeeping
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = device_data_out[7:0];
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers and registered read path
  always_comb begin
    overflow_d = overflow_q;
    divisor_d  = divisor_q;
    data_in_d  = data_in_q;
    if (wr_status && device_data_out[2]) begin
      overflow_d = 1'b0;
    end
    // Set takes priority over a same-cycle clear
    if (wr_txdata && fifo_full) begin
      overflow_d = 1'b1;
    end
    if (wr_divisor) begin
      divisor_d = device_data_out;
    end
    if (device_read_en) begin
      case (device_addr)
        AddrStatus:  data_in_d = status;
        AddrDivisor: data_in_d = divisor_q;
        AddrCoreId:  data_in_d = {13'b0, device_core_id};
        default:     data_in_d = 16'h0000;
      endcase
    end
  end

  // Serializer next-state
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_div_d  = bit_div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          shift_d    = fifo_q[rd_ptr_q];
          bit_div_d  = div_eff;
          baud_cnt_d = div_eff - 16'd1;
          tx_d       = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (baud_done) begin
          tx_d       = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          bit_cnt_d  = 3'd0;
          baud_cnt_d = bit_div_q - 16'd1;
          state_d    = StData;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      StData: begin
        if (baud_done) begin
          baud_cnt_d = bit_div_q - 16'd1;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (baud_done) begin
          state_d = StIdle;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      divisor_q  <= DEFAULT_DIVISOR;
      data_in_q  <= 16'h0000;
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_div_q  <= 16'd1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      divisor_q  <= divisor_d;
      data_in_q  <= data_in_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_div_q  <= bit_div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign device_data_in = data_in_q;
  assign uart_tx        = tx_q;

endmodule

// File: tb/tb_device_uart_tx.sv
// Directed bench for device_uart_tx: register map, frame timing, FIFO overflow, reset abort.
module tb_device_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  device_core_id = 3'd0;
  logic        device_write_en = 1'b0;
  logic        device_read_en = 1'b0;
  logic [9:0]  device_addr = 10'h0;
  logic [15:0] device_data_out = 16'h0;
  logic [15:0] device_data_in;
  logic        uart_tx;

  int total = 0;
  int bad = 0;

  device_uart_tx dut (
    .clk             (clk),
    .reset           (reset),
    .device_core_id  (device_core_id),
    .device_write_en (device_write_en),
    .device_read_en  (device_read_en),
    .device_addr     (device_addr),
    .device_data_out (device_data_out),
    .device_data_in  (device_data_in),
    .uart_tx         (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle; returns 1ns after the sampling edge
  task automatic bus(input logic we, input logic re, input logic [9:0] a, input logic [15:0] d);
    device_write_en = we;
    device_read_en  = re;
    device_addr     = a;
    device_data_out = d;
    @(posedge clk);
    #1;
    device_write_en = 1'b0;
    device_read_en  = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rd_check(input string tag, input logic [9:0] a, input logic [15:0] exp);
    bus(1'b0, 1'b1, a, 16'h0);
    check(tag, device_data_in, exp);
  endtask

  // Starts in the first start-bit cycle; ends in the cycle after the stop bit
  task automatic frame_check(input string tag, input logic [7:0] b, input int div);
    for (int i = 0; i < 10; i++) begin
      logic e;
      e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      for (int c = 0; c < div; c++) begin
        check(tag, {15'b0, uart_tx}, {15'b0, e});
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx", {15'b0, uart_tx}, 16'h0001);
    check("reset_rdata", device_data_in, 16'h0000);
    reset = 1'b0;

    rd_check("status_after_reset", 10'h001, 16'h0000);
    rd_check("divisor_after_reset", 10'h002, 16'd434);
    device_core_id = 3'd5;
    rd_check("coreid", 10'h003, 16'h0005);
    rd_check("unmapped_3ff", 10'h3FF, 16'h0000);
    rd_check("alias_201", 10'h201, 16'h0000);

    // Divisor 4, byte 0x55
    wr(10'h002, 16'd4);
    wr(10'h000, 16'h0055);
    check("pre_pop_idle", {15'b0, uart_tx}, 16'h0001);
    @(posedge clk);
    #1;
    frame_check("frame_55", 8'h55, 4);
    rd_check("status_after_55", 10'h001, 16'h0000);

    // Divisor 0 behaves as 1
    wr(10'h002, 16'd0);
    rd_check("divisor_zero_rd", 10'h002, 16'h0000);
    wr(10'h000, 16'h00A3);
    @(posedge clk);
    #1;
    frame_check("frame_a3_div0", 8'hA3, 1);
    rd_check("status_after_a3", 10'h001, 16'h0000);

    // Divisor change mid-frame applies to the next frame only
    wr(10'h002, 16'd2);
    wr(10'h000, 16'h000F);
    wr(10'h000, 16'h00C4);
    device_write_en = 1'b1;
    device_addr     = 10'h002;
    device_data_out = 16'd8;
    frame_check("frame_0f_div2", 8'h0F, 2);
    device_write_en = 1'b0;
    check("interframe_gap", {15'b0, uart_tx}, 16'h0001);
    @(posedge clk);
    #1;
    frame_check("frame_c4_div8", 8'hC4, 8);
    rd_check("divisor_now_8", 10'h002, 16'd8);
    @(posedge clk);
    #1;
    check("rdata_hold", device_data_in, 16'd8);
    rd_check("status_after_c4", 10'h001, 16'h0000);

    // Fill FIFO: first byte is popped, eight more fill it
    wr(10'h002, 16'd2);
    for (int i = 0; i < 9; i++) wr(10'h000, 16'(8'h30 + i));
    rd_check("status_full", 10'h001, 16'h0003);
    wr(10'h000, 16'h0099);
    rd_check("status_overflow", 10'h001, 16'h0007);
    wr(10'h001, 16'h0004);
    rd_check("status_ovf_cleared", 10'h001, 16'h0003);
    bus(1'b1, 1'b1, 10'h002, 16'd9);
    check("rd_wr_same_cycle", device_data_in, 16'd2);
    rd_check("divisor_after_rw", 10'h002, 16'd9);

    // Reset mid-frame with 3 bytes queued
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr(10'h002, 16'd4);
    for (int i = 0; i < 4; i++) wr(10'h000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_data_bit", {15'b0, uart_tx}, 16'h0000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_abort_tx", {15'b0, uart_tx}, 16'h0001);
    check("reset_abort_rdata", device_data_in, 16'h0000);
    reset = 1'b0;
    rd_check("reset_abort_status", 10'h001, 16'h0000);
    rd_check("reset_abort_divisor", 10'h002, 16'd434);
    for (int i = 0; i < 20; i++) begin
      check("post_reset_idle", {15'b0, uart_tx}, 16'h0001);
      @(posedge clk);
      #1;
    end
    rd_check("post_reset_status", 10'h001, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
